// File: rtl/add_serial_pkg.sv
// rtl/add_serial_pkg.sv - shared constants and FSM encoding for add_serial_sched
//
// Purpose: default adder width/latency, the 3-bit scheduler state encoding and
//          the helper that sizes requester index fields.
// Ports:   none (package).
package add_serial_pkg;

   localparam int DEF_W       = 8;
   localparam int DEF_ADD_LAT = 11;
   localparam int STATE_W     = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_LAUNCH  = 3'd1;
   localparam state_t S_WAIT    = 3'd2;
   localparam state_t S_CAPTURE = 3'd3;
   localparam state_t S_RELEASE = 3'd4;
   localparam state_t S_RESP    = 3'd5;

   // Width of a requester index; never below one bit.
   function automatic int id_w(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

endpackage

// File: rtl/add_serial_sched_rr_arbiter.sv
// rtl/add_serial_sched_rr_arbiter.sv - combinational round-robin pick
//
// Purpose: choose the first asserted request at or above i_ptr, wrapping to
//          the lowest asserted request when none exists above the pointer.
// Ports:
//   i_req     in   N_REQ  request bits
//   i_ptr     in   ID_W   round-robin start position
//   o_any     out  1      at least one request asserted
//   o_onehot  out  N_REQ  one-hot winner
//   o_idx     out  ID_W   index of the winner
module rr_arbiter
   import add_serial_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
)(
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic             o_any,
   output logic [N_REQ-1:0] o_onehot,
   output logic [ID_W-1:0]  o_idx
);

   logic w_hi_found;
   logic w_lo_found;
   logic [ID_W-1:0] w_hi_idx;
   logic [ID_W-1:0] w_lo_idx;

   // Two passes over fixed indices: the upper pass honours the pointer, the
   // lower pass supplies the wrap-around winner.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_hi_found && i_req[k] && (ID_W'(k) >= i_ptr)) begin
            w_hi_found = 1'b1;
            w_hi_idx   = ID_W'(k);
         end
         if (!w_lo_found && i_req[k]) begin
            w_lo_found = 1'b1;
            w_lo_idx   = ID_W'(k);
         end
      end
   end

   always_comb begin
      o_any    = w_hi_found | w_lo_found;
      o_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
      o_onehot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (o_any && (ID_W'(k) == o_idx)) begin
            o_onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/add_serial_sched.sv
// rtl/add_serial_sched.sv - round-robin scheduler sharing one add_serial adder
//
// Purpose: grant one requester, launch the adder, wait its fixed latency,
//          capture the result, release the adder and hand back a tagged response.
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-low reset
//   req        in   N_REQ    level requests
//   req_a      in   N_REQ*W  operand A per requester (slice i = req_a[i*W +: W])
//   req_b      in   N_REQ*W  operand B per requester
//   gnt        out  N_REQ    one-hot single-cycle grant
//   rsp_valid  out  1        response available
//   rsp_ready  in   1        consumer accepts response
//   rsp_id     out  ID_W     owner of rsp_sum
//   rsp_sum    out  W        captured adder result
//   add_en     out  1        adder launch/release pulses
//   add_a      out  W        adder operand a
//   add_b      out  W        adder operand b
//   add_out    in   W        adder result
//   busy       out  1        scheduler not idle
module add_serial_sched
   import add_serial_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int W       = DEF_W,
   parameter int ADD_LAT = DEF_ADD_LAT
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*W-1:0]      req_a,
   input  logic [N_REQ*W-1:0]      req_b,
   output logic [N_REQ-1:0]        gnt,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [id_w(N_REQ)-1:0]  rsp_id,
   output logic [W-1:0]            rsp_sum,
   output logic                    add_en,
   output logic [W-1:0]            add_a,
   output logic [W-1:0]            add_b,
   input  logic [W-1:0]            add_out,
   output logic                    busy
);

   localparam int ID_W = id_w(N_REQ);
   localparam int WC_W = $clog2(ADD_LAT);

   state_t            r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [N_REQ-1:0]  r_gnt;
   logic              r_add_en;
   logic [W-1:0]      r_add_a;
   logic [W-1:0]      r_add_b;
   logic [ID_W-1:0]   r_rsp_id;
   logic [W-1:0]      r_rsp_sum;
   logic              r_rsp_valid;
   logic [WC_W-1:0]   r_wcnt;

   logic              w_arb_any;
   logic [N_REQ-1:0]  w_arb_onehot;
   logic [ID_W-1:0]   w_arb_idx;
   logic [W-1:0]      w_sel_a;
   logic [W-1:0]      w_sel_b;
   logic [ID_W-1:0]   w_ptr_next;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .i_req    (req),
      .i_ptr    (r_rr_ptr),
      .o_any    (w_arb_any),
      .o_onehot (w_arb_onehot),
      .o_idx    (w_arb_idx)
   );

   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_arb_onehot[k]) begin
            w_sel_a = req_a[k*W +: W];
            w_sel_b = req_b[k*W +: W];
         end
      end
   end

   assign w_ptr_next = (r_rsp_id == ID_W'(N_REQ - 1)) ? '0 : r_rsp_id + ID_W'(1);

   // Timeline relative to the grant cycle (0): launch pulse in cycle 1, the
   // counter spans the adder latency, the result is sampled at the same edge
   // that raises the release pulse (cycle ADD_LAT+2), and rsp_valid follows
   // one settle cycle into S_RESP (cycle ADD_LAT+4).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_gnt       <= '0;
         r_add_en    <= 1'b0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_rsp_id    <= '0;
         r_rsp_sum   <= '0;
         r_rsp_valid <= 1'b0;
         r_wcnt      <= '0;
      end else begin
         r_gnt    <= '0;
         r_add_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_arb_any) begin
                  r_gnt    <= w_arb_onehot;
                  r_add_a  <= w_sel_a;
                  r_add_b  <= w_sel_b;
                  r_rsp_id <= w_arb_idx;
                  r_state  <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_add_en <= 1'b1;
               r_wcnt   <= WC_W'(ADD_LAT - 1);
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wcnt == '0) begin
                  r_state <= S_CAPTURE;
               end else begin
                  r_wcnt <= r_wcnt - WC_W'(1);
               end
            end
            S_CAPTURE: begin
               // add_out is final here; the adder only leaves DONE after it
               // samples the release pulse one edge later.
               r_rsp_sum <= add_out;
               r_add_en  <= 1'b1;
               r_state   <= S_RELEASE;
            end
            S_RELEASE: begin
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (!r_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rr_ptr    <= w_ptr_next;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign add_en    = r_add_en;
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign rsp_id    = r_rsp_id;
   assign rsp_sum   = r_rsp_sum;
   assign rsp_valid = r_rsp_valid;
   assign busy      = (r_state != S_IDLE);

endmodule
